// File: rtl/axis_tag_fanout.sv
// ---------------------------------------------------------------------------
// axis_tag_fanout
//
// Distributes one AXI-Stream tag stream to FANOUT consumers. Each output has
// its own first-word-fall-through FIFO, a runtime enable and a selectable
// blocking/lossy mode. Lossy outputs never back-pressure the input; beats they
// cannot store are discarded and counted in a saturating per-output counter.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tdata   input stream
//   m_tvalid/m_tready/m_tdata   FANOUT output streams (output i at
//                               m_tdata[i*DATA_WIDTH +: DATA_WIDTH])
//   cfg_enable     per-output enable for new beats
//   cfg_drop_mode  per-output mode: 0 = blocking, 1 = lossy
//   drop_clear     pulse, clears all drop counters (wins over a same-cycle drop)
//   drop_count     per-output saturating dropped-beat counters
//   fill_level     per-output FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module axis_tag_fanout #(
    parameter int FANOUT     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 32,
    parameter int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_tvalid,
    output logic                        s_tready,
    input  logic [DATA_WIDTH-1:0]       s_tdata,
    output logic [FANOUT-1:0]           m_tvalid,
    input  logic [FANOUT-1:0]           m_tready,
    output logic [FANOUT*DATA_WIDTH-1:0] m_tdata,
    input  logic [FANOUT-1:0]           cfg_enable,
    input  logic [FANOUT-1:0]           cfg_drop_mode,
    input  logic                        drop_clear,
    output logic [FANOUT*CNT_WIDTH-1:0] drop_count,
    output logic [FANOUT*LVL_W-1:0]     fill_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FANOUT-1:0] w_full;
    logic [FANOUT-1:0] w_empty;
    logic [FANOUT-1:0] w_ok;
    logic [FANOUT-1:0] w_wr;
    logic [FANOUT-1:0] w_drop;
    logic [FANOUT-1:0] w_pop;
    logic              w_accept;

    // Input readiness looks only at registered FIFO state and configuration,
    // so there is no combinational path from any m_tready to s_tready.
    assign s_tready = !rst && (&w_ok);
    assign w_accept = s_tvalid && s_tready;

    genvar gi;
    generate
        for (gi = 0; gi < FANOUT; gi++) begin : g_out
            logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            // Pointers carry one extra wrap bit so full and empty differ.
            logic [LVL_W-1:0]      r_wr_ptr;
            logic [LVL_W-1:0]      r_rd_ptr;
            logic [LVL_W-1:0]      w_level;
            logic [CNT_WIDTH-1:0]  r_drop_cnt;

            assign w_level      = r_wr_ptr - r_rd_ptr;
            assign w_full[gi]   = (w_level == LVL_W'(DEPTH));
            assign w_empty[gi]  = (w_level == '0);

            // Disabled or lossy outputs never hold back the input.
            assign w_ok[gi]     = !cfg_enable[gi] || cfg_drop_mode[gi] || !w_full[gi];

            // A pop in the same cycle does not free space for this cycle's
            // write: full is judged on start-of-cycle state only.
            assign w_wr[gi]     = w_accept && cfg_enable[gi] && !w_full[gi];
            assign w_drop[gi]   = w_accept && cfg_enable[gi] && w_full[gi];
            assign w_pop[gi]    = !w_empty[gi] && m_tready[gi];

            // Storage has no reset; only the pointers define valid contents.
            always_ff @(posedge clk) begin
                if (w_wr[gi]) begin
                    r_mem[r_wr_ptr[AW-1:0]] <= s_tdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_wr[gi]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_drop_cnt <= '0;
                end else if (drop_clear) begin
                    r_drop_cnt <= '0;
                end else if (w_drop[gi] && (r_drop_cnt != '1)) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end

            // First-word-fall-through: the head entry is read asynchronously.
            assign m_tvalid[gi]                              = !w_empty[gi];
            assign m_tdata[gi*DATA_WIDTH +: DATA_WIDTH]      = r_mem[r_rd_ptr[AW-1:0]];
            assign drop_count[gi*CNT_WIDTH +: CNT_WIDTH]     = r_drop_cnt;
            assign fill_level[gi*LVL_W +: LVL_W]             = w_level;
        end
    endgenerate

endmodule

// File: tb/tb_axis_tag_fanout.sv
// ---------------------------------------------------------------------------
// tb_axis_tag_fanout
//
// Directed bench for axis_tag_fanout with FANOUT=4, DEPTH=4, CNT_WIDTH=3,
// DATA_WIDTH=16. A per-cycle vector table covers the basic fill/stall/drop/
// clear behaviour; hand-written sequences cover streaming corner cases.
// Output beats are captured at the falling edge into per-output logs.
// ---------------------------------------------------------------------------
module tb_axis_tag_fanout;

    localparam int FO = 4;
    localparam int DW = 16;
    localparam int DP = 4;
    localparam int CW = 3;
    localparam int LW = 3;
    localparam int LOGN = 256;

    logic              clk;
    logic              rst;
    logic              s_tvalid;
    logic              s_tready;
    logic [DW-1:0]     s_tdata;
    logic [FO-1:0]     m_tvalid;
    logic [FO-1:0]     m_tready;
    logic [FO*DW-1:0]  m_tdata;
    logic [FO-1:0]     cfg_enable;
    logic [FO-1:0]     cfg_drop_mode;
    logic              drop_clear;
    logic [FO*CW-1:0]  drop_count;
    logic [FO*LW-1:0]  fill_level;

    int checks = 0;
    int errors = 0;

    axis_tag_fanout #(
        .FANOUT(FO), .DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .cfg_enable(cfg_enable), .cfg_drop_mode(cfg_drop_mode),
        .drop_clear(drop_clear), .drop_count(drop_count),
        .fill_level(fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output capture logs
    logic [DW-1:0] rx_buf [FO][LOGN];
    int            rx_n   [FO];
    int            base   [FO];

    initial begin
        for (int i = 0; i < FO; i++) rx_n[i] = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FO; i++) begin
                if (m_tvalid[i] && m_tready[i]) begin
                    if (rx_n[i] < LOGN) rx_buf[i][rx_n[i]] <= m_tdata[i*DW +: DW];
                    rx_n[i] <= rx_n[i] + 1;
                end
            end
        end
    end

    typedef struct {
        logic          vld;
        logic [DW-1:0] data;
        logic [FO-1:0] rdy;
        logic [FO-1:0] en;
        logic [FO-1:0] mode;
        logic          clr;
        logic          exp_rdy;
        logic [FO-1:0] exp_mv;
        logic [11:0]   exp_fill;
        logic [11:0]   exp_drop;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic vld, input logic [DW-1:0] data,
                                input logic [3:0] rdy, input logic [3:0] en,
                                input logic [3:0] mode, input logic clr,
                                input logic exp_rdy, input logic [3:0] exp_mv,
                                input logic [11:0] exp_fill, input logic [11:0] exp_drop);
        vec_t v;
        v.vld = vld; v.data = data; v.rdy = rdy; v.en = en; v.mode = mode;
        v.clr = clr; v.exp_rdy = exp_rdy; v.exp_mv = exp_mv;
        v.exp_fill = exp_fill; v.exp_drop = exp_drop;
        return v;
    endfunction

    function automatic logic [11:0] rep(input logic [2:0] v);
        return {v, v, v, v};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark_base();
        for (int i = 0; i < FO; i++) base[i] = rx_n[i];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        drop_clear = 1'b0;
        #1;
        chk("rst_tready", {63'd0, s_tready}, 64'd0);
        tick();
        rst = 1'b0;
        mark_base();
    endtask

    // Offer beats first..last in order, advancing on each accept.
    task automatic stream(input int first, input int last, output int cyc);
        int  k;
        logic acc;
        k = first;
        cyc = 0;
        while (k <= last && cyc < 500) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(k);
            #1;
            acc = s_tready;
            tick();
            if (acc) begin
                $display("beat %0h accepted", k);
                k++;
            end
            cyc++;
        end
        s_tvalid = 1'b0;
        chk("stream_done", 64'(k), 64'(last + 1));
    endtask

    task automatic drain(input logic [FO-1:0] mask);
        int cyc;
        cyc = 0;
        while ((m_tvalid & mask) != '0 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("drain", 64'(m_tvalid & mask), 64'd0);
    endtask

    // Compare output i's log since the last mark against first..last.
    task automatic check_seq(input int i, input int first, input int last);
        int n;
        int exp_n;
        n = rx_n[i] - base[i];
        exp_n = (last >= first) ? (last - first + 1) : 0;
        chk($sformatf("count_out%0d", i), 64'(n), 64'(exp_n));
        for (int j = 0; j < exp_n && j < n; j++) begin
            chk($sformatf("data_out%0d_%0d", i, j),
                64'(rx_buf[i][base[i] + j]), 64'(first + j));
        end
    endtask

    initial begin
        int cyc;

        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        m_tready = '0;
        cfg_enable = '1;
        cfg_drop_mode = '0;
        drop_clear = 1'b0;

        // ---------------- Reset state ----------------
        repeat (2) tick();
        chk("rst_tready_hold", {63'd0, s_tready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("post_rst_fill", 64'(fill_level), 64'd0);
        chk("post_rst_drop", 64'(drop_count), 64'd0);
        chk("post_rst_tready", {63'd0, s_tready}, 64'd1);
        mark_base();

        // ---------------- Vector table ----------------
        vecs[0]  = mk(1, 16'h10, 4'hF, 4'hF, 4'h0, 0, 1, 4'h0, rep(3'd0), rep(3'd0));
        vecs[1]  = mk(1, 16'h11, 4'h0, 4'hF, 4'h0, 0, 1, 4'hF, rep(3'd1), rep(3'd0));
        vecs[2]  = mk(1, 16'h12, 4'h0, 4'hF, 4'h0, 0, 1, 4'hF, rep(3'd2), rep(3'd0));
        vecs[3]  = mk(1, 16'h13, 4'h0, 4'hF, 4'h0, 0, 1, 4'hF, rep(3'd3), rep(3'd0));
        vecs[4]  = mk(1, 16'h14, 4'h0, 4'hF, 4'h0, 0, 0, 4'hF, rep(3'd4), rep(3'd0));
        vecs[5]  = mk(1, 16'h14, 4'hF, 4'hF, 4'h0, 0, 0, 4'hF, rep(3'd4), rep(3'd0));
        vecs[6]  = mk(1, 16'h14, 4'h0, 4'hF, 4'h0, 0, 1, 4'hF, rep(3'd3), rep(3'd0));
        vecs[7]  = mk(1, 16'h15, 4'h0, 4'hF, 4'hF, 0, 1, 4'hF, rep(3'd4), rep(3'd0));
        vecs[8]  = mk(0, 16'h00, 4'h0, 4'h0, 4'h0, 0, 1, 4'hF, rep(3'd4), rep(3'd1));
        vecs[9]  = mk(0, 16'h00, 4'hF, 4'hF, 4'h0, 1, 0, 4'hF, rep(3'd4), rep(3'd1));
        vecs[10] = mk(0, 16'h00, 4'hF, 4'hF, 4'h0, 0, 1, 4'hF, rep(3'd3), rep(3'd0));
        vecs[11] = mk(0, 16'h00, 4'hF, 4'hF, 4'h0, 0, 1, 4'hF, rep(3'd2), rep(3'd0));
        vecs[12] = mk(0, 16'h00, 4'hF, 4'hF, 4'h0, 0, 1, 4'hF, rep(3'd1), rep(3'd0));
        vecs[13] = mk(0, 16'h00, 4'h0, 4'hF, 4'h0, 0, 1, 4'h0, rep(3'd0), rep(3'd0));

        for (int v = 0; v < 14; v++) begin
            s_tvalid      = vecs[v].vld;
            s_tdata       = vecs[v].data;
            m_tready      = vecs[v].rdy;
            cfg_enable    = vecs[v].en;
            cfg_drop_mode = vecs[v].mode;
            drop_clear    = vecs[v].clr;
            #1;
            $display("vec %0d tready=%0b mvalid=%h fill=%h drop=%h",
                     v, s_tready, m_tvalid, fill_level, drop_count);
            chk($sformatf("vec%0d_tready", v), {63'd0, s_tready}, {63'd0, vecs[v].exp_rdy});
            chk($sformatf("vec%0d_mvalid", v), 64'(m_tvalid), 64'(vecs[v].exp_mv));
            chk($sformatf("vec%0d_fill", v), 64'(fill_level), 64'(vecs[v].exp_fill));
            chk($sformatf("vec%0d_drop", v), 64'(drop_count), 64'(vecs[v].exp_drop));
            tick();
        end
        s_tvalid = 1'b0;
        drop_clear = 1'b0;
        for (int i = 0; i < FO; i++) check_seq(i, 16'h10, 16'h14);

        // ---------------- Pass-through ----------------
        cfg_enable = '1; cfg_drop_mode = '0; m_tready = '1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(k);
            #1;
            chk($sformatf("pt_tready_%0d", k), {63'd0, s_tready}, 64'd1);
            tick();
            $display("beat %0h accepted", k);
            chk($sformatf("pt_mvalid_%0d", k), 64'(m_tvalid), 64'hF);
            for (int i = 0; i < FO; i++)
                chk($sformatf("pt_head_%0d_%0d", i, k), 64'(m_tdata[i*DW +: DW]), 64'(k));
        end
        s_tvalid = 1'b0;
        tick();
        chk("pt_idle_mvalid", 64'(m_tvalid), 64'd0);
        chk("pt_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < FO; i++) check_seq(i, 0, 7);

        // ---------------- Blocking stall ----------------
        m_tready = 4'b1011;
        do_reset();
        stream(0, 3, cyc);
        chk("blk_first_cycles", 64'(cyc), 64'd4);
        s_tvalid = 1'b1;
        s_tdata  = DW'(4);
        #1;
        chk("blk_tready_low", {63'd0, s_tready}, 64'd0);
        chk("blk_fill2", 64'(fill_level[2*LW +: LW]), 64'd4);
        repeat (2) begin
            tick();
            chk("blk_head2_stable", 64'(m_tdata[2*DW +: DW]), 64'd0);
        end
        check_seq(0, 0, 3);
        check_seq(1, 0, 3);
        check_seq(3, 0, 3);
        m_tready = '1;
        stream(4, 9, cyc);
        drain('1);
        for (int i = 0; i < FO; i++) check_seq(i, 0, 9);

        // ---------------- Lossy ----------------
        cfg_drop_mode = 4'b0010;
        m_tready = 4'b1101;
        do_reset();
        stream(0, 9, cyc);
        chk("lossy_cycles", 64'(cyc), 64'd10);
        drain(4'b1101);
        chk("lossy_fill1", 64'(fill_level[1*LW +: LW]), 64'd4);
        chk("lossy_drop1", 64'(drop_count[1*CW +: CW]), 64'd6);
        check_seq(0, 0, 9);
        check_seq(2, 0, 9);
        check_seq(3, 0, 9);
        m_tready = '1;
        drain(4'b0010);
        check_seq(1, 0, 3);

        // ---------------- Saturation and clear ----------------
        cfg_drop_mode = 4'b0010;
        m_tready = 4'b1101;
        do_reset();
        stream(0, 3, cyc);
        stream(4, 13, cyc);
        chk("sat_cycles", 64'(cyc), 64'd10);
        chk("sat_drop1", 64'(drop_count[1*CW +: CW]), 64'd7);
        chk("sat_drop_others", 64'({drop_count[3*CW +: CW], drop_count[2*CW +: CW],
                                   drop_count[0 +: CW]}), 64'd0);
        s_tvalid   = 1'b1;
        s_tdata    = DW'(14);
        drop_clear = 1'b1;
        #1;
        chk("clr_tready", {63'd0, s_tready}, 64'd1);
        tick();
        $display("beat %0h accepted", 14);
        drop_clear = 1'b0;
        s_tvalid   = 1'b0;
        chk("clr_drop1", 64'(drop_count[1*CW +: CW]), 64'd0);
        stream(15, 15, cyc);
        chk("post_clr_drop1", 64'(drop_count[1*CW +: CW]), 64'd1);
        m_tready = '1;
        drain('1);
        check_seq(1, 0, 3);
        check_seq(0, 0, 15);

        // ---------------- Enable ----------------
        cfg_drop_mode = '0;
        cfg_enable = '0;
        m_tready = '1;
        do_reset();
        stream(0, 4, cyc);
        chk("en_off_cycles", 64'(cyc), 64'd5);
        chk("en_off_mvalid", 64'(m_tvalid), 64'd0);
        chk("en_off_fill", 64'(fill_level), 64'd0);
        chk("en_off_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < FO; i++) check_seq(i, 0, -1);
        cfg_enable = '1;
        m_tready = 4'b0111;
        stream(5, 6, cyc);
        chk("en_fill3", 64'(fill_level[3*LW +: LW]), 64'd2);
        cfg_enable = 4'b0111;
        m_tready = '1;
        stream(7, 9, cyc);
        drain('1);
        check_seq(3, 5, 6);
        for (int i = 0; i < 3; i++) check_seq(i, 5, 9);

        // ---------------- Reset mid-stream ----------------
        cfg_enable = '1;
        m_tready = '0;
        do_reset();
        cfg_enable = 4'b1111; stream(0, 0, cyc);
        cfg_enable = 4'b0101; stream(1, 1, cyc);
        cfg_enable = 4'b1101; stream(2, 2, cyc);
        cfg_enable = 4'b0100; stream(3, 3, cyc);
        cfg_enable = '1;
        chk("mid_fill", 64'(fill_level), 64'({3'd2, 3'd4, 3'd1, 3'd3}));
        rst = 1'b1;
        #1;
        chk("mid_rst_tready", {63'd0, s_tready}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_post_mvalid", 64'(m_tvalid), 64'd0);
        chk("mid_post_fill", 64'(fill_level), 64'd0);
        chk("mid_post_drop", 64'(drop_count), 64'd0);
        chk("mid_post_tready", {63'd0, s_tready}, 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
